// File: rtl/mult_share_arb.sv
// ============================================================================
// Module   : mult_share_arb
// Purpose  : Round-robin sharing of one 8x8 fraction multiplier among
//            NUM_REQ requesters, with tag tracking and response routing.
// Options  : MULT_SHARE_ARB_GRANT_CNT_EN adds saturating per-requester
//            grant counters (o_grant_cnt) with clear input i_cnt_clr.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_share_arb #(
  parameter int NUM_REQ      = 4,
  parameter int MULT_LATENCY = 1,
  parameter int ID_W         = $clog2(NUM_REQ)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_hold,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [NUM_REQ*8-1:0] i_req_a,
  input  logic [NUM_REQ*8-1:0] i_req_b,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic [7:0]           o_mult_a,
  output logic [7:0]           o_mult_b,
  input  logic [7:0]           i_mult_product,
  output logic [NUM_REQ-1:0]   o_rsp_valid,
  output logic [ID_W-1:0]      o_rsp_id,
  output logic [7:0]           o_rsp_product
`ifdef MULT_SHARE_ARB_GRANT_CNT_EN
  ,
  input  logic                 i_cnt_clr,
  output logic [NUM_REQ*16-1:0] o_grant_cnt
`endif
);

  localparam logic [ID_W-1:0] c_LAST_ID = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0]         r_rr_ptr;
  logic [MULT_LATENCY-1:0] r_tag_vld;
  logic [ID_W-1:0]         r_tag_id [MULT_LATENCY];

  logic            w_found;
  logic            w_grant;
  logic [ID_W-1:0] w_win;
  logic            w_rsp_vld;
  logic [ID_W-1:0] w_rsp_id;

  // Scan offsets 0..NUM_REQ-1 from the pointer; the first valid requester wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!w_found && (k == (int'(r_rr_ptr) + i) % NUM_REQ) && i_req_valid[k]) begin
          w_found = 1'b1;
          w_win   = ID_W'(k);
        end
      end
    end
  end

  assign w_grant = w_found && !i_hold && !i_rst;

  always_comb begin
    o_req_ready = '0;
    o_mult_a    = 8'h00;
    o_mult_b    = 8'h00;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_grant && (w_win == ID_W'(k))) begin
        o_req_ready[k] = 1'b1;
        o_mult_a       = i_req_a[k*8 +: 8];
        o_mult_b       = i_req_b[k*8 +: 8];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr_ptr  <= '0;
      r_tag_vld <= '0;
      for (int s = 0; s < MULT_LATENCY; s++) begin
        r_tag_id[s] <= '0;
      end
    end else begin
      r_tag_vld[0] <= w_grant;
      r_tag_id[0]  <= w_win;
      for (int s = 1; s < MULT_LATENCY; s++) begin
        r_tag_vld[s] <= r_tag_vld[s-1];
        r_tag_id[s]  <= r_tag_id[s-1];
      end
      if (w_grant) begin
        r_rr_ptr <= (w_win == c_LAST_ID) ? '0 : w_win + ID_W'(1);
      end
    end
  end

  // Outputs are forced idle during reset so a tag due in that cycle is dropped.
  assign w_rsp_vld = r_tag_vld[MULT_LATENCY-1] && !i_rst;
  assign w_rsp_id  = r_tag_id[MULT_LATENCY-1];

  always_comb begin
    o_rsp_valid   = '0;
    o_rsp_id      = '0;
    o_rsp_product = 8'h00;
    if (w_rsp_vld) begin
      o_rsp_id      = w_rsp_id;
      o_rsp_product = i_mult_product;
      for (int k = 0; k < NUM_REQ; k++) begin
        o_rsp_valid[k] = (w_rsp_id == ID_W'(k));
      end
    end
  end

`ifdef MULT_SHARE_ARB_GRANT_CNT_EN
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_cnt
    logic [15:0] r_cnt;
    always_ff @(posedge i_clk) begin
      if (i_rst || i_cnt_clr) begin
        r_cnt <= 16'h0000;
      end else if (o_req_ready[k] && (r_cnt != 16'hFFFF)) begin
        r_cnt <= r_cnt + 16'h0001;
      end
    end
    assign o_grant_cnt[k*16 +: 16] = r_cnt;
  end
`else
  // Grant counters are not built in this configuration.
`endif

endmodule

`default_nettype wire
